// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_display
//  Purpose  : Multiplexed 7-segment hex display for NUM_CH byte channels.
//             Each channel byte is latched on the rising edge of its valid
//             strobe and shown as two hex digits (low nibble on digit 2k,
//             high nibble on digit 2k+1). The decimal point of digit 2k+1
//             stays lit for FRESH scan steps after each update.
//  Ports    : clk      - sole clock, rising edge
//             rst_n    - synchronous active-low reset
//             data_i   - channel bytes, channel k = data_i[8k+7:8k]
//             valid_i  - per-channel update strobe (level or pulse)
//             freeze_i - suppresses captures while high
//             seg_o    - active-low segments {g,f,e,d,c,b,a}, registered
//             dp_o     - active-low decimal point, registered
//             an_o     - active-low digit enables, an_o[0] = rightmost digit
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_display #(
  parameter int NUM_CH = 2,
  parameter int DIV    = 131072,
  parameter int FRESH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [8*NUM_CH-1:0]   data_i,
  input  logic [NUM_CH-1:0]     valid_i,
  input  logic                  freeze_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [2*NUM_CH-1:0]   an_o
);

  localparam int ND = 2 * NUM_CH;
  localparam int IW = $clog2(ND);
  localparam int CW = $clog2(DIV);

  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(ND - 1);
  localparam logic [7:0]    FRESH_INIT = 8'(FRESH);
  localparam logic [ND-1:0] AN_RESET   = {{(ND-1){1'b1}}, 1'b0};

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CW-1:0]               cnt_q,   cnt_d;
  logic [IW-1:0]               idx_q,   idx_d;
  logic [NUM_CH-1:0]           valid_q, valid_d;
  logic [NUM_CH-1:0][7:0]      byte_q,  byte_d;
  logic [NUM_CH-1:0]           shown_q, shown_d;
  logic [NUM_CH-1:0][7:0]      fresh_q, fresh_d;
  logic [6:0]                  seg_q,   seg_d;
  logic                        dp_q,    dp_d;
  logic [ND-1:0]               an_q,    an_d;

  logic                        tick;
  logic [NUM_CH-1:0]           rise;
  logic [7:0]                  cur_byte;
  logic                        cur_shown;
  logic                        cur_fresh;
  logic                        cur_hi;
  logic [3:0]                  cur_nib;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);

    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    // valid_q always follows valid_i, even while frozen, so that releasing
    // freeze with a strobe still high does not look like a new edge.
    valid_d = valid_i;
    rise    = valid_i & ~valid_q & {NUM_CH{~freeze_i}};

    byte_d  = byte_q;
    shown_d = shown_q;
    fresh_d = fresh_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (tick && (fresh_q[k] != 8'd0)) begin
        fresh_d[k] = fresh_q[k] - 8'd1;
      end
      // A capture overrides the scan-tick decrement on the same edge.
      if (rise[k]) begin
        byte_d[k]  = data_i[8*k +: 8];
        shown_d[k] = 1'b1;
        fresh_d[k] = FRESH_INIT;
      end
    end

    // Output stage is registered from the current index and state.
    cur_byte  = '0;
    cur_shown = 1'b0;
    cur_fresh = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (k == (int'(idx_q) / 2)) begin
        cur_byte  = byte_q[k];
        cur_shown = shown_q[k];
        cur_fresh = (fresh_q[k] != 8'd0);
      end
    end
    cur_hi  = idx_q[0];
    cur_nib = cur_hi ? cur_byte[7:4] : cur_byte[3:0];

    seg_d = cur_shown ? hex7(cur_nib) : 7'h7F;
    dp_d  = ~(cur_shown & cur_hi & cur_fresh);
    for (int i = 0; i < ND; i++) begin
      an_d[i] = (i != int'(idx_q));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= '0;
      byte_q  <= '0;
      shown_q <= '0;
      fresh_q <= '0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= AN_RESET;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      byte_q  <= byte_d;
      shown_q <= shown_d;
      fresh_q <= fresh_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg_o = seg_q;
  assign dp_o  = dp_q;
  assign an_o  = an_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_display
//  Purpose  : Directed self-checking bench for seg_scan_display
//             (NUM_CH=2, DIV=4, FRESH=8) with a per-digit scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_display;

  localparam int NUM_CH = 2;
  localparam int DIV    = 4;
  localparam int FRESH  = 8;
  localparam int ND     = 2 * NUM_CH;

  localparam logic [6:0] HEX_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [8*NUM_CH-1:0]  data;
  logic [NUM_CH-1:0]    valid;
  logic                 freeze;
  logic [6:0]           seg;
  logic                 dp;
  logic [ND-1:0]        an;

  always #5 clk = ~clk;

  seg_scan_display #(.NUM_CH(NUM_CH), .DIV(DIV), .FRESH(FRESH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_i   (data),
    .valid_i  (valid),
    .freeze_i (freeze),
    .seg_o    (seg),
    .dp_o     (dp),
    .an_o     (an)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string      tag;
    int         digit;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input string tag, input int d, input logic [6:0] s, input logic p);
    exp_t e;
    e.tag   = tag;
    e.digit = d;
    e.seg   = s;
    e.dp    = p;
    sb.push_back(e);
  endtask

  // Push the expected appearance of every digit for two channel bytes.
  task automatic push_all(input string tag, input logic [7:0] b0, input logic s0,
                          input logic [7:0] b1, input logic s1);
    push({tag, "_d0"}, 0, s0 ? HEX_TBL[b0[3:0]] : 7'h7F, 1'b1);
    push({tag, "_d1"}, 1, s0 ? HEX_TBL[b0[7:4]] : 7'h7F, 1'b1);
    push({tag, "_d2"}, 2, s1 ? HEX_TBL[b1[3:0]] : 7'h7F, 1'b1);
    push({tag, "_d3"}, 3, s1 ? HEX_TBL[b1[7:4]] : 7'h7F, 1'b1);
  endtask

  // Pop each expectation, wait (bounded) for its digit to be enabled, compare.
  task automatic drain();
    exp_t          e;
    logic [ND-1:0] pat;
    bit            hit;
    repeat (2) @(negedge clk);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      pat = '1;
      pat[e.digit] = 1'b0;
      hit = 1'b0;
      for (int n = 0; n < 4 * DIV * ND; n++) begin
        if (an === pat) begin
          hit = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check({e.tag, "_digit_seen"}, 32'(hit), 32'd1);
      if (hit) begin
        check({e.tag, "_seg"}, 32'(seg), 32'(e.seg));
        check({e.tag, "_dp"},  32'(dp),  32'(e.dp));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] scan_seq [4];
    bit         hit;
    int         dp_low;
    int         dp_wrong;

    scan_seq = '{4'hD, 4'hB, 4'h7, 4'hE};

    // Reset state
    rst_n  = 1'b0;
    valid  = '0;
    data   = '0;
    freeze = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_dp",  32'(dp),  32'h1);
    check("reset_an",  32'(an),  32'hE);

    // Idle scan: every digit enable held DIV cycles, all blank
    rst_n = 1'b1;
    hit   = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (an === 4'hD) begin
        hit = 1'b1;
        break;
      end
    end
    check("scan_start", 32'(hit), 32'd1);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < DIV; c++) begin
        check("scan_an",  32'(an),  32'(scan_seq[s]));
        check("scan_seg", 32'(seg), 32'h7F);
        @(negedge clk);
      end
    end

    // Single-cycle pulse on ch0 with 0xA5; dp freshness window on digit1
    valid = 2'b01;
    data  = 16'h00A5;
    @(negedge clk);
    valid = 2'b00;
    data  = 16'h0000;
    dp_low   = 0;
    dp_wrong = 0;
    for (int n = 0; n < 160; n++) begin
      if (dp === 1'b0) begin
        dp_low++;
        if (an !== 4'hD) dp_wrong++;
      end
      @(negedge clk);
    end
    tests_run++;
    assert (dp_low >= 4 && dp_low <= 8) else begin
      tests_failed++;
      $error("FAIL fresh_dp_cycles: observed %0d expected 4..8", dp_low);
    end
    check("fresh_dp_wrong_digit", 32'(dp_wrong), 32'd0);
    push_all("pulse_a5", 8'hA5, 1'b1, 8'h00, 1'b0);
    drain();

    // Hold valid[1] for 20 cycles while data changes: only the first byte lands
    valid = 2'b10;
    data  = 16'h3C00;
    repeat (5) @(negedge clk);
    data  = 16'h7E00;
    repeat (15) @(negedge clk);
    valid = 2'b00;
    data  = 16'h0000;
    repeat (40) @(negedge clk);
    push_all("hold_3c", 8'hA5, 1'b1, 8'h3C, 1'b1);
    drain();

    // Freeze suppresses a rise; releasing freeze with valid still high is no rise
    freeze = 1'b1;
    @(negedge clk);
    valid = 2'b01;
    data  = 16'h0011;
    repeat (3) @(negedge clk);
    push_all("frozen", 8'hA5, 1'b1, 8'h3C, 1'b1);
    drain();
    freeze = 1'b0;
    repeat (3) @(negedge clk);
    push_all("unfrozen", 8'hA5, 1'b1, 8'h3C, 1'b1);
    drain();
    valid = 2'b00;
    data  = 16'h0000;

    // Simultaneous rises on both channels
    @(negedge clk);
    valid = 2'b11;
    data  = 16'h9621;
    @(negedge clk);
    valid = 2'b00;
    data  = 16'h0000;
    repeat (40) @(negedge clk);
    push_all("both", 8'h21, 1'b1, 8'h96, 1'b1);
    drain();

    // One-cycle reset mid-dwell, coinciding with a rise on ch1
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    valid = 2'b10;
    data  = 16'h5500;
    @(negedge clk);
    check("midreset_seg", 32'(seg), 32'h7F);
    check("midreset_dp",  32'(dp),  32'h1);
    check("midreset_an",  32'(an),  32'hE);
    rst_n = 1'b1;
    valid = 2'b00;
    data  = 16'h0000;
    push_all("after_reset", 8'h00, 1'b0, 8'h00, 1'b0);
    drain();

    // valid already high when reset releases counts as a rise
    rst_n = 1'b0;
    valid = 2'b01;
    data  = 16'h00E7;
    @(negedge clk);
    rst_n = 1'b1;
    push("rel_d0", 0, HEX_TBL[4'h7], 1'b1);
    push("rel_d1", 1, HEX_TBL[4'hE], 1'b0);
    push("rel_d2", 2, 7'h7F, 1'b1);
    push("rel_d3", 3, 7'h7F, 1'b1);
    drain();
    valid = 2'b00;
    data  = 16'h0000;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
